// File: rtl/pwm_softstart_sequencer.sv
// Soft-start / soft-stop sequencer for one half-bridge pwm instance.
// Ramps the highside on-time toward a clamped target one step every
// step_periods pwm periods, tracks target changes, ramps down to zero on
// disable and shuts down immediately on abort. Every new highside/lowside
// pair is followed one cycle later by a single load_enable pulse.
module pwm_softstart_sequencer #(
   parameter int bitwidth     = 8,
   parameter int step_periods = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                abort,
   input  logic                counter_overflow,
   input  logic [bitwidth-1:0] tick_count_period,
   input  logic [bitwidth-1:0] deadtime,
   input  logic [bitwidth-1:0] target_highside,
   input  logic [bitwidth-1:0] step,
   output logic                pwm_reset,
   output logic                load_enable,
   output logic [bitwidth-1:0] tick_count_highside,
   output logic [bitwidth-1:0] tick_count_lowside,
   output logic [1:0]          state,
   output logic                ramp_done
);

   // One extra bit so 2*deadtime and highside+step never wrap.
   localparam int XW = bitwidth + 1;
   localparam int CW = (step_periods > 1) ? $clog2(step_periods) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(step_periods - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_RUN  = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [bitwidth-1:0] hs_q, hs_d;
   logic [bitwidth-1:0] ls_q, ls_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                fire_q, fire_d;       // new values registered, pulse due next cycle
   logic                loaded_q, loaded_d;   // current highside already handed to the pwm
   logic                entry_q, entry_d;     // first cycle after entering RAMP
   logic                load_enable_q, load_enable_d;
   logic                pwm_reset_q;
   logic                ramp_done_q;

   logic [XW-1:0] period_x, two_dt_x, limit_x, target_x, tgt_x, eff_step_x;
   logic [XW-1:0] hs_x, up_sum_x, up_x, down_diff_x, down_x, ramp_x;
   logic          step_hit;

   // Lowside fills whatever the limit leaves; never negative if the limit shrank.
   function automatic logic [bitwidth-1:0] lowside_of(input logic [XW-1:0] lim,
                                                      input logic [XW-1:0] hs);
      return (lim > hs) ? bitwidth'(lim - hs) : '0;
   endfunction

   // Limit, clamped target and candidate next highside values.
   always_comb begin
      period_x    = {1'b0, tick_count_period};
      two_dt_x    = {deadtime, 1'b0};
      limit_x     = (period_x >= two_dt_x) ? (period_x - two_dt_x) : '0;
      target_x    = {1'b0, target_highside};
      tgt_x       = (target_x < limit_x) ? target_x : limit_x;
      eff_step_x  = (step == '0) ? XW'(1) : {1'b0, step};
      hs_x        = {1'b0, hs_q};
      up_sum_x    = hs_x + eff_step_x;
      up_x        = (up_sum_x < tgt_x) ? up_sum_x : tgt_x;
      down_diff_x = (hs_x > eff_step_x) ? (hs_x - eff_step_x) : '0;
      down_x      = (down_diff_x > tgt_x) ? down_diff_x : tgt_x;
      ramp_x      = (hs_x < tgt_x) ? up_x : down_x;
      step_hit    = counter_overflow && (cnt_q == CNT_LAST);
   end

   // Next-state logic: abort > enable low > step on overflow.
   always_comb begin
      state_d  = state_q;
      hs_d     = hs_q;
      ls_d     = ls_q;
      fire_d   = 1'b0;
      loaded_d = loaded_q;
      entry_d  = 1'b0;
      cnt_d    = cnt_q;
      if (counter_overflow) begin
         cnt_d = step_hit ? '0 : (cnt_q + 1'b1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_RAMP;
               entry_d = 1'b1;
            end
         end
         ST_RAMP: begin
            if (!enable) begin
               state_d = ST_STOP;
            end else if (step_hit) begin
               hs_d     = bitwidth'(ramp_x);
               ls_d     = lowside_of(limit_x, ramp_x);
               fire_d   = 1'b1;
               loaded_d = 1'b1;
               if (ramp_x == tgt_x) begin
                  state_d = ST_RUN;
               end
            end else if (entry_q && (hs_x == tgt_x)) begin
               // Already on target when the ramp starts: settle without moving.
               state_d = ST_RUN;
               if (!loaded_q) begin
                  fire_d   = 1'b1;
                  loaded_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_STOP;
            end else if (hs_x != tgt_x) begin
               state_d = ST_RAMP;
               entry_d = 1'b1;
            end
         end
         ST_STOP: begin
            if (enable) begin
               state_d = ST_RAMP;
               entry_d = 1'b1;
            end else if (load_enable_q && (hs_q == '0) && !fire_q) begin
               // The zero value has just been loaded; nothing left in flight.
               state_d = ST_IDLE;
            end else if (step_hit) begin
               hs_d     = bitwidth'(down_diff_x);
               ls_d     = lowside_of(limit_x, down_diff_x);
               fire_d   = 1'b1;
               loaded_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d = ST_IDLE;
         fire_d  = 1'b0;
         entry_d = 1'b0;
      end
      if (state_d != state_q) begin
         cnt_d = '0;
      end
      if (state_d == ST_IDLE) begin
         hs_d     = '0;
         ls_d     = '0;
         cnt_d    = '0;
         loaded_d = 1'b0;
      end
      load_enable_d = abort ? 1'b0 : fire_q;
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         hs_q          <= '0;
         ls_q          <= '0;
         cnt_q         <= '0;
         fire_q        <= 1'b0;
         loaded_q      <= 1'b0;
         entry_q       <= 1'b0;
         load_enable_q <= 1'b0;
         pwm_reset_q   <= 1'b1;
         ramp_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_q          <= hs_d;
         ls_q          <= ls_d;
         cnt_q         <= cnt_d;
         fire_q        <= fire_d;
         loaded_q      <= loaded_d;
         entry_q       <= entry_d;
         load_enable_q <= load_enable_d;
         pwm_reset_q   <= (state_d == ST_IDLE);
         ramp_done_q   <= (state_d == ST_RUN);
      end
   end

   assign pwm_reset           = pwm_reset_q;
   assign load_enable         = load_enable_q;
   assign tick_count_highside = hs_q;
   assign tick_count_lowside  = ls_q;
   assign state               = state_q;
   assign ramp_done           = ramp_done_q;

endmodule

// File: tb/tb_pwm_softstart_sequencer.sv
// Bench for pwm_softstart_sequencer: directed scenarios with literal
// expectations, then randomized stimulus, all compared every cycle against
// an integer reference model driven by the same inputs.
module tb_pwm_softstart_sequencer;

   localparam int BW = 8;
   localparam int SP = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          abort = 1'b0;
   logic          counter_overflow = 1'b0;
   logic [BW-1:0] tick_count_period = 8'd100;
   logic [BW-1:0] deadtime = 8'd5;
   logic [BW-1:0] target_highside = 8'd0;
   logic [BW-1:0] step = 8'd10;
   logic          pwm_reset;
   logic          load_enable;
   logic [BW-1:0] tick_count_highside;
   logic [BW-1:0] tick_count_lowside;
   logic [1:0]    state;
   logic          ramp_done;

   int n_checks = 0;
   int n_fail   = 0;

   pwm_softstart_sequencer #(.bitwidth(BW), .step_periods(SP)) dut (
      .clock               (clock),
      .reset               (reset),
      .enable              (enable),
      .abort               (abort),
      .counter_overflow    (counter_overflow),
      .tick_count_period   (tick_count_period),
      .deadtime            (deadtime),
      .target_highside     (target_highside),
      .step                (step),
      .pwm_reset           (pwm_reset),
      .load_enable         (load_enable),
      .tick_count_highside (tick_count_highside),
      .tick_count_lowside  (tick_count_lowside),
      .state               (state),
      .ramp_done           (ramp_done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // States: 0 idle, 1 ramp, 2 run, 3 stop. Load pulses are kept as a
   // queue of edge numbers at which load_enable must rise.
   int m_state, m_hs, m_ls, m_cnt, m_le, m_prst, m_done;
   bit m_loaded, m_entry, model_on = 1'b0;
   int due[$];
   int e_idx = 0;

   initial begin
      int lim, tgt, es, nst, nh;
      bit pend, hit, fire, was_entry;
      forever begin
         @(posedge clock);
         e_idx++;
         if (reset) begin
            m_state = 0; m_hs = 0; m_ls = 0; m_cnt = 0; m_le = 0;
            m_prst = 1; m_done = 0; m_loaded = 0; m_entry = 0;
            due.delete();
            model_on = 1'b1;
         end else begin
            pend = (due.size() > 0) && (due[0] == e_idx);
            if (pend) void'(due.pop_front());
            lim = (int'(tick_count_period) >= 2 * int'(deadtime)) ?
                  int'(tick_count_period) - 2 * int'(deadtime) : 0;
            tgt = (int'(target_highside) < lim) ? int'(target_highside) : lim;
            es  = (step == 0) ? 1 : int'(step);
            was_entry = m_entry;
            m_entry = 0;
            hit = 0;
            if (counter_overflow && m_state != 0) begin
               m_cnt++;
               if (m_cnt == SP) begin hit = 1; m_cnt = 0; end
            end
            nst = m_state;
            fire = 0;
            if (abort) begin
               nst = 0;
               pend = 0;
               due.delete();
            end else begin
               case (m_state)
                  0: if (enable) begin nst = 1; m_entry = 1; end
                  1: begin
                     if (!enable) nst = 3;
                     else if (hit) begin
                        if (m_hs < tgt) nh = (m_hs + es < tgt) ? m_hs + es : tgt;
                        else begin
                           nh = (m_hs - es > 0) ? m_hs - es : 0;
                           if (nh < tgt) nh = tgt;
                        end
                        m_hs = nh;
                        m_ls = (lim > nh) ? lim - nh : 0;
                        fire = 1;
                        if (nh == tgt) nst = 2;
                     end else if (was_entry && m_hs == tgt) begin
                        nst = 2;
                        fire = !m_loaded;
                     end
                  end
                  2: begin
                     if (!enable) nst = 3;
                     else if (m_hs != tgt) begin nst = 1; m_entry = 1; end
                  end
                  default: begin
                     if (enable) begin nst = 1; m_entry = 1; end
                     else if (m_le == 1 && m_hs == 0 && !pend) nst = 0;
                     else if (hit) begin
                        nh = (m_hs - es > 0) ? m_hs - es : 0;
                        m_hs = nh;
                        m_ls = (lim > nh) ? lim - nh : 0;
                        fire = 1;
                     end
                  end
               endcase
            end
            if (fire) begin
               due.push_back(e_idx + 1);
               m_loaded = 1;
            end
            if (nst != m_state) m_cnt = 0;
            if (nst == 0) begin
               m_hs = 0; m_ls = 0; m_cnt = 0; m_loaded = 0; m_entry = 0;
            end
            m_le    = pend ? 1 : 0;
            m_state = nst;
            m_prst  = (nst == 0) ? 1 : 0;
            m_done  = (nst == 2) ? 1 : 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clock) begin
      if (model_on) begin
         check("cyc_state", state, m_state);
         check("cyc_highside", tick_count_highside, m_hs);
         check("cyc_lowside", tick_count_lowside, m_ls);
         check("cyc_load_enable", load_enable, m_le);
         check("cyc_pwm_reset", pwm_reset, m_prst);
         check("cyc_ramp_done", ramp_done, m_done);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_ovf();
      counter_overflow = 1'b1;
      @(negedge clock);
      counter_overflow = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; abort = 1'b0; counter_overflow = 1'b0;
      idle(2);
      reset = 1'b0;
      idle(1);
   endtask

   task automatic set_cfg(input int per, input int dt, input int tg, input int st);
      tick_count_period = 8'(per);
      deadtime          = 8'(dt);
      target_highside   = 8'(tg);
      step              = 8'(st);
   endtask

   initial begin
      int sum_le;
      @(negedge clock);
      do_reset();
      check("rst_state", state, 0);
      check("rst_pwm_reset", pwm_reset, 1);
      check("rst_load_enable", load_enable, 0);
      check("rst_highside", tick_count_highside, 0);
      check("rst_lowside", tick_count_lowside, 0);
      check("rst_ramp_done", ramp_done, 0);

      // T1: ramp 10/20/30/40, lowside 80..50
      set_cfg(100, 5, 40, 10);
      enable = 1'b1;
      idle(3);
      check("t1_state_ramp", state, 1);
      check("t1_pwm_reset_low", pwm_reset, 0);
      for (int i = 1; i <= 8; i++) begin
         pulse_ovf();
         if (i % 2 == 0) begin
            check("t1_highside", tick_count_highside, 5 * i);
            check("t1_lowside", tick_count_lowside, 90 - 5 * i);
         end
         if (i == 2) begin
            check("t1_load_lat0", load_enable, 0);
            idle(1);
            check("t1_load_lat1", load_enable, 1);
            idle(1);
            check("t1_load_lat2", load_enable, 0);
            idle(1);
         end else begin
            idle(3);
         end
      end
      check("t1_state_run", state, 2);
      check("t1_ramp_done", ramp_done, 1);
      check("t1_model_hs", m_hs, 40);

      // T2: target 45 -> one more step clamped at 45
      target_highside = 8'd45;
      idle(2);
      check("t2_state_ramp", state, 1);
      check("t2_ramp_done_low", ramp_done, 0);
      pulse_ovf(); idle(3); pulse_ovf(); idle(3);
      check("t2_highside", tick_count_highside, 45);
      check("t2_lowside", tick_count_lowside, 45);
      check("t2_state_run", state, 2);

      // T3: back to 40, then soft-stop 30/20/10/0 and IDLE
      target_highside = 8'd40;
      idle(2);
      pulse_ovf(); idle(3); pulse_ovf(); idle(3);
      check("t3_hs_40", tick_count_highside, 40);
      enable = 1'b0;
      idle(2);
      check("t3_state_stop", state, 3);
      for (int i = 1; i <= 8; i++) begin
         pulse_ovf();
         idle(3);
         if (i % 2 == 0 && i < 8) check("t3_highside", tick_count_highside, 40 - 5 * i);
      end
      check("t3_state_idle", state, 0);
      check("t3_pwm_reset", pwm_reset, 1);
      check("t3_highside_0", tick_count_highside, 0);

      // T4: abort at highside 20 with a load pulse in flight
      enable = 1'b1;
      idle(3);
      for (int i = 1; i <= 3; i++) begin pulse_ovf(); idle(3); end
      pulse_ovf();
      check("t4_hs_20", tick_count_highside, 20);
      abort = 1'b1; enable = 1'b0;
      idle(1);
      check("t4_state_idle", state, 0);
      check("t4_highside", tick_count_highside, 0);
      check("t4_lowside", tick_count_lowside, 0);
      check("t4_pwm_reset", pwm_reset, 1);
      check("t4_load_enable", load_enable, 0);
      abort = 1'b0;
      idle(1);
      check("t4_no_late_load", load_enable, 0);

      // T5a: target 250 clamps to limit 90
      do_reset();
      set_cfg(100, 5, 250, 50);
      enable = 1'b1;
      idle(3);
      for (int i = 1; i <= 4; i++) begin pulse_ovf(); idle(3); end
      check("t5_highside", tick_count_highside, 90);
      check("t5_lowside", tick_count_lowside, 0);
      check("t5_state_run", state, 2);
      check("t5_model_hs", m_hs, 90);

      // T5b: limit 0 -> RUN at 0 with exactly one load pulse
      do_reset();
      set_cfg(8, 5, 40, 10);
      enable = 1'b1;
      sum_le = 0;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         sum_le += int'(load_enable);
      end
      check("t5_limit0_pulses", sum_le, 1);
      check("t5_limit0_state", state, 2);
      check("t5_limit0_hs", tick_count_highside, 0);

      // T6a: step 0 -> increments of 1
      do_reset();
      set_cfg(100, 5, 40, 0);
      enable = 1'b1;
      idle(3);
      for (int i = 1; i <= 4; i++) begin pulse_ovf(); idle(3); end
      check("t6_step0_hs", tick_count_highside, 2);
      check("t6_step0_ls", tick_count_lowside, 88);

      // T6b: overflow coincident with enable fall at 20
      do_reset();
      set_cfg(100, 5, 40, 10);
      enable = 1'b1;
      idle(3);
      for (int i = 1; i <= 5; i++) begin pulse_ovf(); idle(3); end
      check("t6_hs_20", tick_count_highside, 20);
      enable = 1'b0;
      pulse_ovf();
      idle(2);
      check("t6_state_stop", state, 3);
      check("t6_hold_20", tick_count_highside, 20);
      pulse_ovf(); idle(3);
      check("t6_hold_20b", tick_count_highside, 20);
      pulse_ovf(); idle(3);
      check("t6_hs_10", tick_count_highside, 10);
      check("t6_model_hs", m_hs, 10);

      // Randomized phase, checked by the model every cycle.
      do_reset();
      set_cfg(100, 5, 60, 7);
      enable = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         reset            = ($urandom_range(0, 499) == 0);
         abort            = ($urandom_range(0, 299) == 0);
         counter_overflow = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 79) == 0) enable = ~enable;
         if ($urandom_range(0, 39) == 0) target_highside = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 99) == 0)
            step = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
         if ($urandom_range(0, 199) == 0) begin
            tick_count_period = 8'($urandom_range(0, 255));
            deadtime          = 8'($urandom_range(0, 70));
         end
         @(negedge clock);
      end
      reset = 1'b0; abort = 1'b0; counter_overflow = 1'b0;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected finish earlier", $time);
      $fatal(1);
   end

endmodule
